pmem_arbiter: RTL and testbench

Two-client arbiter between the instruction cache and data cache miss paths and the single shared physical-memory (cacheline adapter) port. Sits directly downstream of the icache controller, which issues demand and prefetch line reads, and the dcache controller, which issues line reads and writebacks. It latches the winning request, drives one full-line transaction downstream, and routes the response back to the winner.

---
 rtl/cache_types_pkg.sv | 35 +++
 rtl/pmem_arbiter.sv | 128 ++++++++++++
 tb/tb_pmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
// Shared types for the cache miss-path arbitration logic: arbiter state,
// client identity, default bus widths and the grant selection helper.
package cache_types_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_t;

  // Pick the client to grant. On a tie, the client not served last wins so
  // that two continuously requesting clients alternate.
  function automatic client_t arb_pick(input logic    i_req,
                                       input logic    d_req,
                                       input client_t last_grant);
    client_t pick;
    if (i_req && d_req) begin
      pick = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
    end else if (d_req) begin
      pick = CLIENT_D;
    end else begin
      pick = CLIENT_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Two-client arbiter between the icache and dcache miss paths and the single
// shared physical-memory port. The winning request is latched at grant time,
// one full-line transaction is driven downstream from the latched copy, and
// the completion strobe is steered back to the winner with no added latency.
module pmem_arbiter
  import cache_types_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned LINE_W = DEFAULT_LINE_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q;
  client_t           last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              pmem_read_q;
  logic              pmem_write_q;

  logic              i_req;
  logic              d_req;
  logic              grant_valid;
  client_t           grant_client;
  logic              grant_write_d;
  logic [ADDR_W-1:0] grant_addr_d;
  logic [LINE_W-1:0] grant_wdata_d;

  assign i_req = i_pmem_read;
  // A dcache read and write asserted together is served as a writeback.
  assign d_req = d_pmem_read | d_pmem_write;

  // Select the winner and the request fields that will be latched on grant.
  always_comb begin
    grant_valid   = i_req | d_req;
    grant_client  = arb_pick(i_req, d_req, last_grant_q);
    grant_write_d = 1'b0;
    grant_addr_d  = i_pmem_address;
    grant_wdata_d = '0;
    if (grant_client == CLIENT_D) begin
      grant_write_d = d_pmem_write;
      grant_addr_d  = d_pmem_address;
      grant_wdata_d = d_pmem_wdata;
    end else begin
      grant_write_d = 1'b0;
      grant_addr_d  = i_pmem_address;
      grant_wdata_d = '0;
    end
  end

  // Arbiter FSM: grant from IDLE, hold the latched transaction until the
  // downstream completion, then spend one IDLE cycle with strobes low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q      <= (grant_client == CLIENT_I) ? SERVE_I : SERVE_D;
            addr_q       <= grant_addr_d;
            wdata_q      <= grant_wdata_d;
            pmem_read_q  <= ~grant_write_d;
            pmem_write_q <= grant_write_d;
          end else begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          // The downstream side is never aborted: a client dropping its
          // request here has no effect until the completion arrives.
          if (pmem_resp) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            last_grant_q <= (state_q == SERVE_I) ? CLIENT_I : CLIENT_D;
          end else begin
            state_q      <= state_q;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Read data is broadcast; only the completion strobes identify the owner.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: table-driven transactions plus
// directed sequences for alternation and reset during a transaction.
module tb_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_cmp = 0;
  int n_err = 0;
  int lat_cfg = 2;

  typedef struct packed {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [7:0]    lat;
    logic          b2b;
  } exp_t;

  typedef struct packed {
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [7:0]    lat;
    logic          d_first;
    logic          chg_i;
    logic          drop_i;
  } vec_t;

  exp_t exp_q[$];

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mkexp(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                                 input logic [LW-1:0] wdata, input logic [7:0] lat, input logic b2b);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.lat = lat; e.b2b = b2b;
    return e;
  endfunction

  function automatic vec_t mkvec(input logic i_rd, input logic [AW-1:0] i_addr,
                                 input logic d_rd, input logic d_wr, input logic [AW-1:0] d_addr,
                                 input logic [LW-1:0] d_wdata, input logic [7:0] lat,
                                 input logic d_first, input logic chg_i, input logic drop_i);
    vec_t v;
    v.i_rd = i_rd; v.i_addr = i_addr; v.d_rd = d_rd; v.d_wr = d_wr; v.d_addr = d_addr;
    v.d_wdata = d_wdata; v.lat = lat; v.d_first = d_first; v.chg_i = chg_i; v.drop_i = drop_i;
    return v;
  endfunction

  // Downstream adapter model: completion in the lat_cfg-th strobe cycle.
  initial begin : responder
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= lat_cfg) begin
          pmem_resp = 1'b1;
          pmem_rdata = line_of(pmem_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: pop the expected transaction when a strobe rises, then check
  // the downstream fields every cycle and the steering of the completion.
  initial begin : monitor
    exp_t cur;
    bit   active;
    int   scyc, cyc, last_resp;
    logic strobe, ei, ed;
    active = 1'b0; scyc = 0; cyc = 0; last_resp = -10; cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      strobe = pmem_read | pmem_write;
      if (strobe && !active) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_txn: got addr %0h write %0b required no transaction", pmem_address, pmem_write);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        if (cur.b2b) chk("idle_gap", 256'(cyc - last_resp - 1), 256'(1));
        active = 1'b1;
        scyc = 0;
      end
      if (strobe && active) begin
        scyc++;
        chk("op_write", 256'(pmem_write), 256'(cur.wr));
        chk("op_read", 256'(pmem_read), 256'(!cur.wr));
        chk("addr", 256'(pmem_address), 256'(cur.addr));
        if (cur.wr) chk("wdata", pmem_wdata, cur.wdata);
      end
      ei = active && strobe && pmem_resp && !cur.is_d;
      ed = active && strobe && pmem_resp && cur.is_d;
      chk("i_resp", 256'(i_pmem_resp), 256'(ei));
      chk("d_resp", 256'(d_pmem_resp), 256'(ed));
      if (active && pmem_resp) begin
        if (cur.is_d) chk("d_rdata", d_pmem_rdata, line_of(cur.addr));
        else          chk("i_rdata", i_pmem_rdata, line_of(cur.addr));
        chk("occupancy", 256'(scyc), 256'(cur.lat));
        last_resp = cyc;
        active = 1'b0;
      end
      if (!strobe) active = 1'b0;
    end
  end

  task automatic clear_inputs();
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_read", 256'(pmem_read), 256'(0));
    chk("rst_write", 256'(pmem_write), 256'(0));
    chk("rst_addr", 256'(pmem_address), 256'(0));
    chk("rst_wdata", pmem_wdata, 256'(0));
  endtask

  // Drive one table entry from IDLE and hold each request until its resp.
  task automatic run_vec(input vec_t v);
    bit i_done, d_done;
    exp_t ei, ed;
    @(posedge clk); #1;
    lat_cfg = int'(v.lat);
    ei = mkexp(1'b0, 1'b0, v.i_addr, '0, v.lat, 1'b0);
    ed = mkexp(1'b1, v.d_wr, v.d_addr, v.d_wdata, v.lat, 1'b0);
    if (v.i_rd && (v.d_rd || v.d_wr)) begin
      if (v.d_first) begin ei.b2b = 1'b1; exp_q.push_back(ed); exp_q.push_back(ei); end
      else           begin ed.b2b = 1'b1; exp_q.push_back(ei); exp_q.push_back(ed); end
    end else if (v.i_rd) begin
      exp_q.push_back(ei);
    end else begin
      exp_q.push_back(ed);
    end
    i_pmem_read = v.i_rd; i_pmem_address = v.i_addr;
    d_pmem_read = v.d_rd; d_pmem_write = v.d_wr; d_pmem_address = v.d_addr; d_pmem_wdata = v.d_wdata;
    i_done = !v.i_rd;
    d_done = !(v.d_rd || v.d_wr);
    for (int c = 0; c < 200 && !(i_done && d_done); c++) begin
      @(negedge clk);
      if (c == 1) chk("grant_latency", 256'(pmem_read | pmem_write), 256'(1));
      if (i_pmem_resp) i_done = 1'b1;
      if (d_pmem_resp) d_done = 1'b1;
      @(posedge clk); #1;
      if (c == 1 && v.chg_i) i_pmem_address = v.i_addr + 32'h20;
      if (i_done || (c == 1 && v.drop_i)) i_pmem_read = 1'b0;
      if (d_done) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    end
    if (!(i_done && d_done)) begin
      n_cmp++; n_err++;
      $display("FAIL vec_timeout: got i_done %0b d_done %0b required both 1", i_done, d_done);
      clear_inputs();
    end
  endtask

  initial begin : main
    vec_t vecs[9];
    int n;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_read", 256'(pmem_read), 256'(0));
    chk("rst_write", 256'(pmem_write), 256'(0));
    chk("rst_i_resp", 256'(i_pmem_resp), 256'(0));
    chk("rst_d_resp", 256'(d_pmem_resp), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // last_grant starts at I and evolves through the table as annotated.
    vecs[0] = mkvec(1, 32'h0000_1000, 0, 0, 32'h0, '0, 8'd5, 0, 0, 0);                // I   -> I
    vecs[1] = mkvec(0, 32'h0, 1, 0, 32'h0000_2000, '0, 8'd1, 0, 0, 0);                 // D   -> D
    vecs[2] = mkvec(0, 32'h0, 0, 1, 32'h0000_3000, {8{32'h5A5A_0003}}, 8'd2, 0, 0, 0); // Dw  -> D
    vecs[3] = mkvec(1, 32'h0000_4000, 1, 1, 32'h0000_5000, {8{32'h1234_5678}}, 8'd3, 0, 0, 0); // I,Dw -> D
    vecs[4] = mkvec(1, 32'h0000_6000, 1, 0, 32'h0000_7000, '0, 8'd1, 0, 0, 0);         // I,D -> D
    vecs[5] = mkvec(1, 32'h0000_8000, 0, 0, 32'h0, '0, 8'd2, 0, 0, 0);                 // I   -> I
    vecs[6] = mkvec(1, 32'h0000_9000, 0, 1, 32'h0000_A000, {8{32'hDEAD_BEEF}}, 8'd4, 1, 0, 0); // Dw,I -> I
    vecs[7] = mkvec(1, 32'h0000_0100, 0, 0, 32'h0, '0, 8'd6, 0, 1, 0);                 // addr change
    vecs[8] = mkvec(1, 32'h0000_0140, 0, 0, 32'h0, '0, 8'd4, 0, 0, 1);                 // request dropped
    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Tie straight out of reset: dcache wins first.
    do_reset();
    run_vec(mkvec(1, 32'h0000_0100, 0, 1, 32'h0000_0200, {32{8'hAA}}, 8'd2, 1, 0, 0));

    // Both clients request continuously: D, I, D, I with one idle cycle each.
    do_reset();
    @(posedge clk); #1;
    lat_cfg = 2;
    exp_q.push_back(mkexp(1'b1, 1'b0, 32'h0000_2200, '0, 8'd2, 1'b0));
    exp_q.push_back(mkexp(1'b0, 1'b0, 32'h0000_1100, '0, 8'd2, 1'b1));
    exp_q.push_back(mkexp(1'b1, 1'b0, 32'h0000_2200, '0, 8'd2, 1'b1));
    exp_q.push_back(mkexp(1'b0, 1'b0, 32'h0000_1100, '0, 8'd2, 1'b1));
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2200;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (i_pmem_resp || d_pmem_resp) n++;
    end
    @(posedge clk); #1;
    clear_inputs();
    chk("b2b_resp_count", 256'(n), 256'(4));

    // Reset while serving the dcache: no resp, strobes low, then normal grant.
    @(posedge clk); #1;
    lat_cfg = 20;
    exp_q.push_back(mkexp(1'b1, 1'b0, 32'h0000_2400, '0, 8'd20, 1'b0));
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2400;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("serve_d_read", 256'(pmem_read), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    d_pmem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_read", 256'(pmem_read), 256'(0));
    chk("abort_write", 256'(pmem_write), 256'(0));
    chk("abort_d_resp", 256'(d_pmem_resp), 256'(0));
    run_vec(mkvec(1, 32'h0000_0500, 0, 0, 32'h0, '0, 8'd2, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
